wb_pack: RTL and testbench

WB_PACK -- requirements
Module: wb_pack

---
 rtl/wb_pack.sv | 258 +++++++++++++++++++++++++
 tb/tb_wb_pack.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_pack.sv
// wb_pack: write-back packer. It packs 4/8-bit feature-map items into 64-bit SRAM words and
// 6-bit guard maps into 48-bit SRAM words. Both accumulators are zero-padded on flush.
// Optional feature: define WB_PACK_STATS_EN to enable the saturating word counters.
module wb_pack #(
    parameter int unsigned FM_ADDR_W = 10,
    parameter int unsigned GD_ADDR_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ctrl_valid,
    output logic                 ctrl_ready,
    output logic                 ctrl_finish,
    input  logic [FM_ADDR_W-1:0] fm_base_i,
    input  logic [GD_ADDR_W-1:0] gd_base_i,
    input  logic [7:0]           data_i,
    input  logic                 data_i_valid,
    input  logic                 bit_mode_i,
    input  logic [5:0]           guard_i,
    input  logic                 guard_i_valid,
    input  logic                 flush_i,
    output logic                 fm_wr_en,
    output logic [FM_ADDR_W-1:0] fm_wr_addr,
    output logic [63:0]          fm_wr_data,
    output logic                 gd_wr_en,
    output logic [GD_ADDR_W-1:0] gd_wr_addr,
    output logic [47:0]          gd_wr_data,
    output logic                 overflow_o,
    output logic                 err_o,
    output logic [15:0]          fm_word_cnt_o,
    output logic [15:0]          gd_word_cnt_o
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StFlush = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    logic [1:0]           r_state,      w_state_next;
    logic [63:0]          r_fm_acc,     w_fm_acc_next;
    logic [3:0]           r_fm_ptr,     w_fm_ptr_next;
    logic [FM_ADDR_W-1:0] r_fm_addr,    w_fm_addr_next;
    logic [47:0]          r_gd_acc,     w_gd_acc_next;
    logic [2:0]           r_gd_cnt,     w_gd_cnt_next;
    logic [GD_ADDR_W-1:0] r_gd_addr,    w_gd_addr_next;
    logic                 r_fm_wr_en,   w_fm_wr_en_next;
    logic [FM_ADDR_W-1:0] r_fm_wr_addr, w_fm_wr_addr_next;
    logic [63:0]          r_fm_wr_data, w_fm_wr_data_next;
    logic                 r_gd_wr_en,   w_gd_wr_en_next;
    logic [GD_ADDR_W-1:0] r_gd_wr_addr, w_gd_wr_addr_next;
    logic [47:0]          r_gd_wr_data, w_gd_wr_data_next;
    logic                 r_ovf,        w_ovf_next;
    logic                 r_err,        w_err_next;

    // Packing results for the current beat, valid whenever a beat is present.
    logic [63:0] w_fm_pack;
    logic [4:0]  w_fm_sum;
    logic        w_fm_carry;
    logic [5:0]  w_nib_idx;
    logic [5:0]  w_odd_idx;
    logic [47:0] w_gd_pack;
    logic [5:0]  w_gd_idx;

    assign w_nib_idx = {r_fm_ptr, 2'b00};
    assign w_odd_idx = {r_fm_ptr + 4'd1, 2'b00};
    assign w_gd_idx  = {3'b000, r_gd_cnt} * 6'd6;

    // Place the incoming item into the FM accumulator. Untouched nibbles stay zero, so the
    // odd-pointer pad nibble needs no explicit write.
    always_comb begin
        w_fm_pack  = r_fm_acc;
        w_fm_sum   = {1'b0, r_fm_ptr};
        w_fm_carry = 1'b0;
        if (bit_mode_i) begin
            w_fm_pack[w_nib_idx +: 4] = data_i[3:0];
            w_fm_sum = {1'b0, r_fm_ptr} + 5'd1;
        end else if (!r_fm_ptr[0]) begin
            w_fm_pack[w_nib_idx +: 8] = data_i;
            w_fm_sum = {1'b0, r_fm_ptr} + 5'd2;
        end else if (r_fm_ptr == 4'd15) begin
            // Pad fills the last nibble; the byte spills into the next word.
            w_fm_sum   = 5'd18;
            w_fm_carry = 1'b1;
        end else begin
            w_fm_pack[w_odd_idx +: 8] = data_i;
            w_fm_sum = {1'b0, r_fm_ptr} + 5'd3;
        end
    end

    // Place the incoming guard map into the next free slot.
    always_comb begin
        w_gd_pack = r_gd_acc;
        w_gd_pack[w_gd_idx +: 6] = guard_i;
    end

    // FSM, accumulator and write-port next-state logic.
    always_comb begin
        w_state_next      = r_state;
        w_fm_acc_next     = r_fm_acc;
        w_fm_ptr_next     = r_fm_ptr;
        w_fm_addr_next    = r_fm_addr;
        w_gd_acc_next     = r_gd_acc;
        w_gd_cnt_next     = r_gd_cnt;
        w_gd_addr_next    = r_gd_addr;
        w_fm_wr_en_next   = 1'b0;
        w_fm_wr_addr_next = r_fm_wr_addr;
        w_fm_wr_data_next = r_fm_wr_data;
        w_gd_wr_en_next   = 1'b0;
        w_gd_wr_addr_next = r_gd_wr_addr;
        w_gd_wr_data_next = r_gd_wr_data;
        w_ovf_next        = r_ovf;
        w_err_next        = r_err;

        case (r_state)
            StIdle: begin
                if (ctrl_valid) begin
                    w_state_next   = StRun;
                    w_fm_addr_next = fm_base_i;
                    w_gd_addr_next = gd_base_i;
                    w_fm_acc_next  = '0;
                    w_fm_ptr_next  = '0;
                    w_gd_acc_next  = '0;
                    w_gd_cnt_next  = '0;
                    w_ovf_next     = 1'b0;
                    w_err_next     = 1'b0;
                end
            end
            StRun: begin
                if (data_i_valid) begin
                    if (w_fm_sum[4]) begin
                        w_fm_wr_en_next   = 1'b1;
                        w_fm_wr_addr_next = r_fm_addr;
                        w_fm_wr_data_next = w_fm_pack;
                        w_fm_addr_next    = r_fm_addr + 1'b1;
                        if (&r_fm_addr) w_ovf_next = 1'b1;
                        w_fm_acc_next = w_fm_carry ? {56'd0, data_i} : 64'd0;
                        w_fm_ptr_next = w_fm_carry ? 4'd2 : 4'd0;
                    end else begin
                        w_fm_acc_next = w_fm_pack;
                        w_fm_ptr_next = w_fm_sum[3:0];
                    end
                end
                if (guard_i_valid) begin
                    if (r_gd_cnt == 3'd7) begin
                        w_gd_wr_en_next   = 1'b1;
                        w_gd_wr_addr_next = r_gd_addr;
                        w_gd_wr_data_next = w_gd_pack;
                        w_gd_addr_next    = r_gd_addr + 1'b1;
                        if (&r_gd_addr) w_ovf_next = 1'b1;
                        w_gd_acc_next = '0;
                    end else begin
                        w_gd_acc_next = w_gd_pack;
                    end
                    w_gd_cnt_next = r_gd_cnt + 3'd1;
                end
                // The beat above is already packed when flush takes effect.
                if (flush_i) w_state_next = StFlush;
            end
            StFlush: begin
                if (r_fm_ptr != 4'd0) begin
                    w_fm_wr_en_next   = 1'b1;
                    w_fm_wr_addr_next = r_fm_addr;
                    w_fm_wr_data_next = r_fm_acc;
                    w_fm_addr_next    = r_fm_addr + 1'b1;
                    if (&r_fm_addr) w_ovf_next = 1'b1;
                end
                if (r_gd_cnt != 3'd0) begin
                    w_gd_wr_en_next   = 1'b1;
                    w_gd_wr_addr_next = r_gd_addr;
                    w_gd_wr_data_next = r_gd_acc;
                    w_gd_addr_next    = r_gd_addr + 1'b1;
                    if (&r_gd_addr) w_ovf_next = 1'b1;
                end
                w_fm_acc_next = '0;
                w_fm_ptr_next = '0;
                w_gd_acc_next = '0;
                w_gd_cnt_next = '0;
                w_state_next  = StDone;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase

        // Beats arriving outside RUN are dropped and flagged.
        if ((r_state != StRun) && (data_i_valid || guard_i_valid)) w_err_next = 1'b1;
    end

    // State registers; asynchronous reset kills any pending write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= StIdle;
            r_fm_acc     <= '0;
            r_fm_ptr     <= '0;
            r_fm_addr    <= '0;
            r_gd_acc     <= '0;
            r_gd_cnt     <= '0;
            r_gd_addr    <= '0;
            r_fm_wr_en   <= 1'b0;
            r_fm_wr_addr <= '0;
            r_fm_wr_data <= '0;
            r_gd_wr_en   <= 1'b0;
            r_gd_wr_addr <= '0;
            r_gd_wr_data <= '0;
            r_ovf        <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_fm_acc     <= w_fm_acc_next;
            r_fm_ptr     <= w_fm_ptr_next;
            r_fm_addr    <= w_fm_addr_next;
            r_gd_acc     <= w_gd_acc_next;
            r_gd_cnt     <= w_gd_cnt_next;
            r_gd_addr    <= w_gd_addr_next;
            r_fm_wr_en   <= w_fm_wr_en_next;
            r_fm_wr_addr <= w_fm_wr_addr_next;
            r_fm_wr_data <= w_fm_wr_data_next;
            r_gd_wr_en   <= w_gd_wr_en_next;
            r_gd_wr_addr <= w_gd_wr_addr_next;
            r_gd_wr_data <= w_gd_wr_data_next;
            r_ovf        <= w_ovf_next;
            r_err        <= w_err_next;
        end
    end

    assign ctrl_ready  = (r_state == StIdle);
    assign ctrl_finish = (r_state == StDone);
    assign fm_wr_en    = r_fm_wr_en;
    assign fm_wr_addr  = r_fm_wr_addr;
    assign fm_wr_data  = r_fm_wr_data;
    assign gd_wr_en    = r_gd_wr_en;
    assign gd_wr_addr  = r_gd_wr_addr;
    assign gd_wr_data  = r_gd_wr_data;
    assign overflow_o  = r_ovf;
    assign err_o       = r_err;

`ifdef WB_PACK_STATS_EN
    logic [15:0] r_fm_words;
    logic [15:0] r_gd_words;

    // Saturating counts of words written since reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fm_words <= '0;
            r_gd_words <= '0;
        end else begin
            if (r_fm_wr_en && (r_fm_words != 16'hFFFF)) r_fm_words <= r_fm_words + 16'd1;
            if (r_gd_wr_en && (r_gd_words != 16'hFFFF)) r_gd_words <= r_gd_words + 16'd1;
        end
    end

    assign fm_word_cnt_o = r_fm_words;
    assign gd_word_cnt_o = r_gd_words;
`else
    assign fm_word_cnt_o = 16'd0;
    assign gd_word_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_wb_pack.sv
// Testbench for wb_pack: directed table vectors, hand-written corner sequences and
// randomized jobs checked against a nibble-stream reference model.
module tb_wb_pack;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ctrl_valid = 1'b0;
    logic        ctrl_ready;
    logic        ctrl_finish;
    logic [9:0]  fm_base_i = '0;
    logic [7:0]  gd_base_i = '0;
    logic [7:0]  data_i = '0;
    logic        data_i_valid = 1'b0;
    logic        bit_mode_i = 1'b0;
    logic [5:0]  guard_i = '0;
    logic        guard_i_valid = 1'b0;
    logic        flush_i = 1'b0;
    logic        fm_wr_en;
    logic [9:0]  fm_wr_addr;
    logic [63:0] fm_wr_data;
    logic        gd_wr_en;
    logic [7:0]  gd_wr_addr;
    logic [47:0] gd_wr_data;
    logic        overflow_o;
    logic        err_o;
    logic [15:0] fm_word_cnt_o;
    logic [15:0] gd_word_cnt_o;

    wb_pack #(.FM_ADDR_W(10), .GD_ADDR_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .ctrl_valid    (ctrl_valid),
        .ctrl_ready    (ctrl_ready),
        .ctrl_finish   (ctrl_finish),
        .fm_base_i     (fm_base_i),
        .gd_base_i     (gd_base_i),
        .data_i        (data_i),
        .data_i_valid  (data_i_valid),
        .bit_mode_i    (bit_mode_i),
        .guard_i       (guard_i),
        .guard_i_valid (guard_i_valid),
        .flush_i       (flush_i),
        .fm_wr_en      (fm_wr_en),
        .fm_wr_addr    (fm_wr_addr),
        .fm_wr_data    (fm_wr_data),
        .gd_wr_en      (gd_wr_en),
        .gd_wr_addr    (gd_wr_addr),
        .gd_wr_data    (gd_wr_data),
        .overflow_o    (overflow_o),
        .err_o         (err_o),
        .fm_word_cnt_o (fm_word_cnt_o),
        .gd_word_cnt_o (gd_word_cnt_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int fails   = 0;
    int fin_cnt = 0;
    int fin_cyc = 0;
    int fl_cyc  = 0;

    logic [9:0]  q_fm_addr[$];
    logic [63:0] q_fm_data[$];
    logic [7:0]  q_gd_addr[$];
    logic [47:0] q_gd_data[$];

    // Collect SRAM writes and finish pulses shortly after each rising edge.
    always @(posedge clk) begin
        #2;
        if (fm_wr_en) begin
            q_fm_addr.push_back(fm_wr_addr);
            q_fm_data.push_back(fm_wr_data);
        end
        if (gd_wr_en) begin
            q_gd_addr.push_back(gd_wr_addr);
            q_gd_data.push_back(gd_wr_data);
        end
        if (ctrl_finish) begin
            fin_cnt = fin_cnt + 1;
            fin_cyc = cyc;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        vectors = vectors + 1;
        if (got !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic clear_q();
        q_fm_addr.delete();
        q_fm_data.delete();
        q_gd_addr.delete();
        q_gd_data.delete();
    endtask

    task automatic beat(input logic dv, input logic [7:0] d, input logic m,
                        input logic gv, input logic [5:0] g, input logic fl);
        @(negedge clk);
        data_i_valid  = dv;
        data_i        = d;
        bit_mode_i    = m;
        guard_i_valid = gv;
        guard_i       = g;
        flush_i       = fl;
        if (fl) fl_cyc = cyc;
    endtask

    task automatic quiet();
        beat(1'b0, 8'h00, 1'b0, 1'b0, 6'h00, 1'b0);
    endtask

    task automatic start_job(input logic [9:0] fb, input logic [7:0] gb);
        @(negedge clk);
        ctrl_valid = 1'b1;
        fm_base_i  = fb;
        gd_base_i  = gb;
        @(negedge clk);
        ctrl_valid = 1'b0;
    endtask

    task automatic wait_finish(input string nm);
        int  c0;
        bit  seen;
        c0   = fin_cnt;
        seen = 1'b0;
        quiet();
        for (int i = 0; i < 20; i++) begin
            if (fin_cnt != c0) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({nm, " finish"}, 64'(seen), 64'd1);
    endtask

    typedef struct {
        logic [9:0]  base;
        int          n;
        logic        mode;
        logic [7:0]  first;
        logic [7:0]  step;
        int          words;
        logic [9:0]  a0;
        logic [63:0] d0;
        logic [9:0]  a1;
        logic [63:0] d1;
        logic        ovf;
    } vec_t;

    vec_t vt[4];

    task automatic run_vec(input int i);
        logic [7:0] it;
        string      nm;
        nm = $sformatf("vec%0d", i);
        clear_q();
        start_job(vt[i].base, 8'h00);
        for (int k = 0; k < vt[i].n; k++) begin
            it = vt[i].first + vt[i].step * 8'(k);
            beat(1'b1, it, vt[i].mode, 1'b0, 6'h00, 1'b0);
        end
        beat(1'b0, 8'h00, 1'b0, 1'b0, 6'h00, 1'b1);
        wait_finish(nm);
        check({nm, " words"}, 64'(q_fm_data.size()), 64'(vt[i].words));
        check({nm, " addr0"}, 64'(q_fm_addr[0]), 64'(vt[i].a0));
        check({nm, " data0"}, q_fm_data[0], vt[i].d0);
        if (vt[i].words > 1) begin
            check({nm, " addr1"}, 64'(q_fm_addr[1]), 64'(vt[i].a1));
            check({nm, " data1"}, q_fm_data[1], vt[i].d1);
        end
        check({nm, " overflow"}, 64'(overflow_o), 64'(vt[i].ovf));
    endtask

    initial begin
        logic [3:0]  nq[$];
        logic [5:0]  gq[$];
        logic [9:0]  fb;
        logic [7:0]  gb;
        logic [63:0] ew;
        logic [47:0] eg;
        logic        dv, gv, m, fl;
        logic [7:0]  d;
        logic [5:0]  g;
        int          nbeats, nw, ng, idx;

        vt[0] = '{10'h010, 16, 1'b1, 8'h01, 8'h01, 1, 10'h010, 64'h0FEDCBA987654321,
                  10'h000, 64'h0, 1'b0};
        vt[1] = '{10'h010, 16, 1'b0, 8'h11, 8'h11, 2, 10'h010, 64'h8877665544332211,
                  10'h011, 64'h10FFEEDDCCBBAA99, 1'b0};
        vt[2] = '{10'h3FF, 32, 1'b0, 8'h00, 8'h01, 4, 10'h3FF, 64'h0706050403020100,
                  10'h000, 64'h0F0E0D0C0B0A0908, 1'b1};
        vt[3] = '{10'h020, 5, 1'b1, 8'h03, 8'h02, 1, 10'h020, 64'h00000000000B9753,
                  10'h000, 64'h0, 1'b0};

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        check("rst ready", 64'(ctrl_ready), 64'd1);
        check("rst finish", 64'(ctrl_finish), 64'd0);
        check("rst fm_wr_en", 64'(fm_wr_en), 64'd0);
        check("rst gd_wr_en", 64'(gd_wr_en), 64'd0);
        check("rst fm_wr_data", fm_wr_data, 64'd0);
        check("rst overflow", 64'(overflow_o), 64'd0);
        check("rst err", 64'(err_o), 64'd0);
        check("rst fm_cnt", 64'(fm_word_cnt_o), 64'd0);
        rst = 1'b0;

        // Table-driven directed jobs.
        for (int i = 0; i < 4; i++) run_vec(i);

        // Mixed widths with a pad nibble, finish two cycles after flush.
        clear_q();
        start_job(10'h040, 8'h00);
        check("run ready low", 64'(ctrl_ready), 64'd0);
        beat(1'b1, 8'h0A, 1'b1, 1'b0, 6'h00, 1'b0);
        beat(1'b1, 8'h5B, 1'b0, 1'b0, 6'h00, 1'b0);
        beat(1'b0, 8'h00, 1'b0, 1'b0, 6'h00, 1'b1);
        wait_finish("pad");
        check("pad words", 64'(q_fm_data.size()), 64'd1);
        check("pad data", q_fm_data[0], 64'h0000_0000_0000_5B0A);
        check("pad addr", 64'(q_fm_addr[0]), 64'h040);
        check("pad finish delay", 64'(fin_cyc - fl_cyc), 64'd2);

        // Partial guard word on flush.
        clear_q();
        start_job(10'h050, 8'h20);
        beat(1'b0, 8'h00, 1'b0, 1'b1, 6'h01, 1'b0);
        beat(1'b0, 8'h00, 1'b0, 1'b1, 6'h02, 1'b0);
        beat(1'b0, 8'h00, 1'b0, 1'b1, 6'h03, 1'b0);
        beat(1'b0, 8'h00, 1'b0, 1'b0, 6'h00, 1'b1);
        wait_finish("guard");
        check("guard words", 64'(q_gd_data.size()), 64'd1);
        check("guard data", 64'(q_gd_data[0]), 64'h3081);
        check("guard addr", 64'(q_gd_addr[0]), 64'h20);
        check("guard fm words", 64'(q_fm_data.size()), 64'd0);

        // Beats outside RUN flag an error, cleared by the next accept.
        clear_q();
        beat(1'b1, 8'h12, 1'b0, 1'b1, 6'h05, 1'b0);
        quiet();
        check("err set", 64'(err_o), 64'd1);
        start_job(10'h060, 8'h00);
        check("err cleared", 64'(err_o), 64'd0);
        beat(1'b0, 8'h00, 1'b0, 1'b0, 6'h00, 1'b1);
        wait_finish("err job");
        check("err job writes", 64'(q_fm_data.size() + q_gd_data.size()), 64'd0);

        // Reset in the middle of a job drops the partial word.
        clear_q();
        start_job(10'h010, 8'h00);
        for (int k = 0; k < 5; k++) beat(1'b1, 8'(k + 1), 1'b1, 1'b0, 6'h00, 1'b0);
        quiet();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("midrst ready", 64'(ctrl_ready), 64'd1);
        check("midrst fm writes", 64'(q_fm_data.size()), 64'd0);
        rst = 1'b0;
        run_vec(0);

        // Randomized jobs against the nibble-stream model.
        for (int j = 0; j < 6; j++) begin
            clear_q();
            nq.delete();
            gq.delete();
            fb = 10'($urandom_range(0, 10'h2FF));
            gb = 8'($urandom_range(0, 8'h7F));
            start_job(fb, gb);
            nbeats = $urandom_range(0, 60);
            for (int b = 0; b <= nbeats; b++) begin
                dv = ($urandom % 4) != 0;
                gv = ($urandom % 3) == 0;
                m  = 1'($urandom % 2);
                d  = 8'($urandom);
                g  = 6'($urandom);
                fl = (b == nbeats);
                beat(dv, d, m, gv, g, fl);
                if (dv) begin
                    if (m) begin
                        nq.push_back(d[3:0]);
                    end else begin
                        if (nq.size() % 2 == 1) nq.push_back(4'h0);
                        nq.push_back(d[3:0]);
                        nq.push_back(d[7:4]);
                    end
                end
                if (gv) gq.push_back(g);
            end
            wait_finish($sformatf("rnd%0d", j));
            nw = (nq.size() + 15) / 16;
            ng = (gq.size() + 7) / 8;
            check($sformatf("rnd%0d fm words", j), 64'(q_fm_data.size()), 64'(nw));
            check($sformatf("rnd%0d gd words", j), 64'(q_gd_data.size()), 64'(ng));
            for (int w = 0; w < nw && w < q_fm_data.size(); w++) begin
                ew = '0;
                for (int n = 0; n < 16; n++) begin
                    idx = w * 16 + n;
                    if (idx < nq.size()) ew[4*n +: 4] = nq[idx];
                end
                check($sformatf("rnd%0d fm data%0d", j, w), q_fm_data[w], ew);
                check($sformatf("rnd%0d fm addr%0d", j, w), 64'(q_fm_addr[w]),
                      64'(fb + 10'(w)));
            end
            for (int w = 0; w < ng && w < q_gd_data.size(); w++) begin
                eg = '0;
                for (int n = 0; n < 8; n++) begin
                    idx = w * 8 + n;
                    if (idx < gq.size()) eg[6*n +: 6] = gq[idx];
                end
                check($sformatf("rnd%0d gd data%0d", j, w), 64'(q_gd_data[w]), 64'(eg));
                check($sformatf("rnd%0d gd addr%0d", j, w), 64'(q_gd_addr[w]),
                      64'(gb + 8'(w)));
            end
            check($sformatf("rnd%0d overflow", j), 64'(overflow_o), 64'd0);
            check($sformatf("rnd%0d err", j), 64'(err_o), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
